// File: rtl/fdiv_seq.sv
// fdiv_seq: sequencer around the iterative SRT single-precision divider core.
// Screens IEEE-754 special operands locally, otherwise issues a one-cycle
// req to the divider, holds its operands, captures the result after DIV_LAT
// edges and applies exponent overflow/underflow fix-up.
// Optional: define FDIV_SEQ_PERF_EN to add perf_ops / perf_special counters.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1; valid never depends on ready, and once out_valid is raised the
// result stays stable until it is taken.
module fdiv_seq #(
  parameter int unsigned DIV_LAT = 28
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rslt,
  output logic [4:0]  out_flag,
  output logic        div_req,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic [31:0] div_rslt,
  input  logic [4:0]  div_flag
`ifdef FDIV_SEQ_PERF_EN
  ,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_special
`endif
);

  localparam int          CNT_W    = $clog2(DIV_LAT + 1);
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [4:0]  FL_NV    = 5'b10000;
  localparam logic [4:0]  FL_DZ    = 5'b01000;
  localparam logic [4:0]  FL_OF_NX = 5'b00101;
  localparam logic [4:0]  FL_UF_NX = 5'b00011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               div_req_q, div_req_d;
  logic [31:0]        out_rslt_q, out_rslt_d;
  logic [4:0]         out_flag_q, out_flag_d;
  logic [31:0]        div_x_q, div_x_d;
  logic [31:0]        div_y_q, div_y_d;

  // only NX of the divider flags is meaningful
  logic unused_div_flag;
  assign unused_div_flag = ^div_flag[4:1];

  logic        x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, x_snan, y_snan;
  logic        sign_in, sp_hit;
  logic [31:0] sp_rslt;
  logic [4:0]  sp_flag;

  // Classify the incoming pair; denormals (exp==0) count as signed zero.
  always_comb begin
    x_zero  = (in_x[30:23] == 8'h00);
    y_zero  = (in_y[30:23] == 8'h00);
    x_inf   = (in_x[30:23] == 8'hFF) && (in_x[22:0] == 23'h0);
    y_inf   = (in_y[30:23] == 8'hFF) && (in_y[22:0] == 23'h0);
    x_nan   = (in_x[30:23] == 8'hFF) && (in_x[22:0] != 23'h0);
    y_nan   = (in_y[30:23] == 8'hFF) && (in_y[22:0] != 23'h0);
    x_snan  = x_nan && !in_x[22];
    y_snan  = y_nan && !in_y[22];
    sign_in = in_x[31] ^ in_y[31];
    sp_hit  = 1'b1;
    sp_rslt = 32'h0;
    sp_flag = 5'h0;
    if (x_nan || y_nan) begin
      sp_rslt = QNAN;
      sp_flag = (x_snan || y_snan) ? FL_NV : 5'h0;
    end else if ((x_inf && y_inf) || (x_zero && y_zero)) begin
      sp_rslt = QNAN;
      sp_flag = FL_NV;
    end else if (x_inf) begin
      sp_rslt = {sign_in, 8'hFF, 23'h0};
    end else if (y_zero) begin
      sp_rslt = {sign_in, 8'hFF, 23'h0};
      sp_flag = FL_DZ;
    end else if (x_zero || y_inf) begin
      sp_rslt = {sign_in, 31'h0};
    end else begin
      sp_hit  = 1'b0;
    end
  end

  logic signed [9:0] e_raw, e_adj;
  logic              sign_op;
  logic [31:0]       fix_rslt;
  logic [4:0]        fix_flag;

  // Exponent fix-up on the held operands: the core cannot signal range errors.
  always_comb begin
    sign_op  = div_x_q[31] ^ div_y_q[31];
    e_raw    = $signed({2'b00, div_x_q[30:23]}) - $signed({2'b00, div_y_q[30:23]}) + 10'sd127;
    e_adj    = e_raw - ((div_x_q[22:0] < div_y_q[22:0]) ? 10'sd1 : 10'sd0);
    fix_rslt = div_rslt;
    fix_flag = {4'h0, div_flag[0]};
    if (e_adj >= 10'sd255) begin
      fix_rslt = {sign_op, 8'hFF, 23'h0};
      fix_flag = FL_OF_NX;
    end else if (e_adj <= 10'sd0) begin
      fix_rslt = {sign_op, 31'h0};
      fix_flag = FL_UF_NX;
    end else if (div_rslt[30:23] == 8'hFF) begin
      // rounding carried the mantissa into the top exponent
      fix_rslt = {sign_op, 8'hFF, 23'h0};
      fix_flag = FL_OF_NX;
    end
  end

  // Next-state logic for the sequencer and its registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    div_req_d   = 1'b0;
    out_rslt_d  = out_rslt_q;
    out_flag_d  = out_flag_q;
    div_x_d     = div_x_q;
    div_y_d     = div_y_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          div_x_d    = in_x;
          div_y_d    = in_y;
          in_ready_d = 1'b0;
          if (sp_hit) begin
            out_rslt_d  = sp_rslt;
            out_flag_d  = sp_flag;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            div_req_d = 1'b1;
            cnt_d     = CNT_W'(DIV_LAT);
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          out_rslt_d  = fix_rslt;
          out_flag_d  = fix_flag;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      div_req_q   <= 1'b0;
      out_rslt_q  <= 32'h0;
      out_flag_q  <= 5'h0;
      div_x_q     <= 32'h0;
      div_y_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      div_req_q   <= div_req_d;
      out_rslt_q  <= out_rslt_d;
      out_flag_q  <= out_flag_d;
      div_x_q     <= div_x_d;
      div_y_q     <= div_y_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign div_req   = div_req_q;
  assign out_rslt  = out_rslt_q;
  assign out_flag  = out_flag_q;
  assign div_x     = div_x_q;
  assign div_y     = div_y_q;

`ifdef FDIV_SEQ_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_special_q, perf_special_d;

  // Count accepted operations and the subset answered locally.
  always_comb begin
    perf_ops_d     = perf_ops_q;
    perf_special_d = perf_special_q;
    if (state_q == S_IDLE && in_valid) begin
      perf_ops_d = perf_ops_q + 32'd1;
      if (sp_hit) perf_special_d = perf_special_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_ops_q     <= 32'h0;
      perf_special_q <= 32'h0;
    end else begin
      perf_ops_q     <= perf_ops_d;
      perf_special_q <= perf_special_d;
    end
  end

  assign perf_ops     = perf_ops_q;
  assign perf_special = perf_special_q;
`endif

endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: bench for fdiv_seq. Models the divider core on the div_*
// port (garbage except when the result is due) and checks every result
// against an arithmetic reference of the IEEE division and screening rules.
module tb_fdiv_seq;
  localparam int DIV_LAT = 28;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = 32'h0;
  logic [31:0] in_y = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rslt;
  logic [4:0]  out_flag;
  logic        div_req;
  logic [31:0] div_x;
  logic [31:0] div_y;
  logic [31:0] div_rslt = 32'h0;
  logic [4:0]  div_flag = 5'h0;
`ifdef FDIV_SEQ_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_special;
`endif

  fdiv_seq #(.DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_rslt(out_rslt), .out_flag(out_flag),
    .div_req(div_req), .div_x(div_x), .div_y(div_y), .div_rslt(div_rslt), .div_flag(div_flag)
`ifdef FDIV_SEQ_PERF_EN
    , .perf_ops(perf_ops), .perf_special(perf_special)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int req_cnt  = 0;
  int stab_err = 0;
  int n_ops    = 0;
  int n_sp     = 0;
  bit track    = 1'b0;
  logic [31:0] cur_x = 32'h0, cur_y = 32'h0;
  logic [37:0] exp_q[$];  // {special, rslt, flag}

  always @(posedge clk) cyc++;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void ieee_div(input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] r, output logic nx);
    logic [63:0] mx, my, num, q, rem, mant;
    int e;
    logic g, s;
    mx = {40'h0, 1'b1, x[22:0]};
    my = {40'h0, 1'b1, y[22:0]};
    e = int'(x[30:23]) - int'(y[30:23]) + 127;
    if (mx < my) begin mx = mx << 1; e = e - 1; end
    num  = mx << 25;
    q    = num / my;
    rem  = num % my;
    mant = q >> 2;
    g    = q[1];
    s    = q[0] | (rem != 0);
    if (g && (s || mant[0])) mant = mant + 1;
    if (mant[24]) begin mant = mant >> 1; e = e + 1; end
    r  = {x[31] ^ y[31], e[7:0], mant[22:0]};
    nx = g | s;
  endfunction

  function automatic void ref_op(input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic [4:0] f, output bit sp);
    int ex, ey, e;
    bit xz, yz, xi, yi, xn, yn, xs, ys;
    logic sg, nx;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);  yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    xs = xn && !x[22];
    ys = yn && !y[22];
    sg = x[31] ^ y[31];
    sp = 1'b1;
    f  = 5'h00;
    r  = 32'h0;
    if (xn || yn) begin
      r = 32'h7FC00000; f = (xs || ys) ? 5'h10 : 5'h00;
    end else if ((xi && yi) || (xz && yz)) begin
      r = 32'h7FC00000; f = 5'h10;
    end else if (xi) begin
      r = {sg, 8'hFF, 23'h0};
    end else if (yz) begin
      r = {sg, 8'hFF, 23'h0}; f = 5'h08;
    end else if (xz || yi) begin
      r = {sg, 31'h0};
    end else begin
      sp = 1'b0;
      e = ex - ey + 127 - ((x[22:0] < y[22:0]) ? 1 : 0);
      if (e >= 255) begin
        r = {sg, 8'hFF, 23'h0}; f = 5'h05;
      end else if (e <= 0) begin
        r = {sg, 31'h0}; f = 5'h03;
      end else begin
        ieee_div(x, y, r, nx);
        if (r[30:23] == 8'hFF) begin
          r = {sg, 8'hFF, 23'h0}; f = 5'h05;
        end else begin
          f = {4'h0, nx};
        end
      end
    end
  endfunction

  // ---------------- divider core model ----------------
  int dm_cnt = 0;
  logic [31:0] dm_r;
  logic dm_nx;
  always @(posedge clk) begin
    if (!reset) dm_cnt = 0;
    else if (div_req) begin dm_cnt = 1; ieee_div(div_x, div_y, dm_r, dm_nx); end
    else if (dm_cnt != 0) dm_cnt = dm_cnt + 1;
    if (dm_cnt > DIV_LAT) dm_cnt = 0;
    #1;
    if (dm_cnt == DIV_LAT - 1) begin
      div_rslt = dm_r;
      div_flag = {4'($urandom()), dm_nx};
    end else begin
      div_rslt = $urandom();
      div_flag = 5'($urandom());
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (div_req) req_cnt++;
    if (track && (div_x !== cur_x || div_y !== cur_y)) stab_err++;
  end

  // ---------------- driver tasks ----------------
  task automatic handshake(input logic [31:0] x, input logic [31:0] y);
    int n;
    in_x = x; in_y = y; in_valid = 1'b1; req_cnt = 0;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check_eq("in_ready_wait", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc - 1;
    in_valid = 1'b0;
    cur_x = x; cur_y = y; stab_err = 0; track = 1'b1;
    n_ops++;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r; logic [4:0] f; bit sp;
    handshake(x, y);
    ref_op(x, y, r, f, sp);
    if (sp) n_sp++;
    exp_q.push_back({sp, r, f});
  endtask

  task automatic send_k(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] r, input logic [4:0] f, input bit sp);
    handshake(x, y);
    if (sp) n_sp++;
    exp_q.push_back({sp, r, f});
  endtask

  task automatic recv(input int delay);
    logic [37:0] e;
    int n, lat, errs;
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    lat = cyc - acc_cyc;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 38'h0;
    check_eq("out_valid_seen", out_valid, 1);
    check_eq("latency", lat, e[37] ? 1 : DIV_LAT + 1);
    check_eq("out_rslt", out_rslt, e[36:5]);
    check_eq("out_flag", out_flag, e[4:0]);
    check_eq("div_req_pulses", req_cnt, e[37] ? 0 : 1);
    errs = 0;
    repeat (delay) begin
      @(negedge clk);
      if (out_rslt !== e[36:5] || out_valid !== 1'b1 || in_ready !== 1'b0) errs++;
    end
    check_eq("done_hold", errs, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    track = 1'b0;
    check_eq("retired", {out_valid, in_ready}, 2'b01);
    check_eq("div_hold", stab_err, 0);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] v, rnd;
    int k;
    rnd = $urandom();
    v = rnd;
    k = $urandom_range(0, 15);
    case (k)
      0: v[30:0] = 31'h0;
      1: v[30:0] = {8'hFF, 23'h0};
      2: v[30:22] = 9'h1FF;
      3: v[30:0] = {8'hFF, 1'b0, rnd[21:1], 1'b1};
      4: v[30:0] = {8'h00, rnd[22:1], 1'b1};
      5: v[30:23] = ($urandom_range(0, 1) == 1) ? 8'd254 : 8'd1;
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int errs, n, outs;
    logic [31:0] x, y;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_div_req", div_req, 0);
    check_eq("rst_out_rslt", out_rslt, 0);
    check_eq("rst_out_flag", out_flag, 0);
    check_eq("rst_div_x", div_x, 0);
    check_eq("rst_div_y", div_y, 0);
    reset = 1'b1;
    @(negedge clk);

    // directed vectors and boundaries
    send_k(32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 0); recv(0);
    send_k(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 0); recv(2);
    send_k(32'h3F800000, 32'h00000000, 32'h7F800000, 5'h08, 1); recv(0);
    send_k(32'h00000000, 32'h80000000, 32'h7FC00000, 5'h10, 1); recv(1);
    send_k(32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'h10, 1); recv(0);
    send_k(32'h3F800000, 32'hFFC00000, 32'h7FC00000, 5'h00, 1); recv(0);
    send_k(32'h7F800000, 32'h00000000, 32'h7F800000, 5'h00, 1); recv(0);
    send_k(32'hFF800000, 32'h3F800000, 32'hFF800000, 5'h00, 1); recv(0);
    send_k(32'h00000001, 32'h3F800000, 32'h00000000, 5'h00, 1); recv(0);
    send_k(32'h3F800000, 32'h80000001, 32'hFF800000, 5'h08, 1); recv(0);
    send_k(32'h3F800000, 32'h7F800000, 32'h00000000, 5'h00, 1); recv(0);
    send_k(32'h7F000000, 32'h3E800000, 32'h7F800000, 5'h05, 0); recv(0);
    send_k(32'h00800000, 32'h4B000000, 32'h00000000, 5'h03, 0); recv(0);
    send_k(32'h00800000, 32'h3F800000, 32'h00800000, 5'h00, 0); recv(0);
    send_k(32'h80800000, 32'h3F800001, 32'h80000000, 5'h03, 0); recv(0);
    send_k(32'h7F000000, 32'h3F000000, 32'h7F800000, 5'h05, 0); recv(0);
    send_k(32'h7F000000, 32'h3F800000, 32'h7F000000, 5'h00, 0); recv(0);

    // backpressure in DONE with a waiting input
    send_k(32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 0);
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    check_eq("bp_valid", out_valid, 1);
    in_x = 32'h3F800000; in_y = 32'h40400000; in_valid = 1'b1;
    errs = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_rslt !== 32'h40400000 || in_ready !== 1'b0 || out_valid !== 1'b1) errs++;
    end
    check_eq("bp_hold", errs, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    track = 1'b0;
    check_eq("bp_retire", {out_valid, in_ready}, 2'b01);
    send_k(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 0);
    check_eq("bp_next_accept", acc_cyc, cyc - 1);
    recv(0);

    // reset in the middle of RUN
    send_k(32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 0);
    repeat (12) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_div_req", div_req, 0);
    reset = 1'b1;
    track = 1'b0;
    exp_q.delete();
    n_ops = 0; n_sp = 0;
    outs = 0;
    repeat (40) begin @(negedge clk); if (out_valid) outs++; end
    check_eq("mid_rst_no_output", outs, 0);
    send_k(32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 0); recv(0);

    // randomized operands against the reference
    for (int i = 0; i < 40; i++) begin
      x = rand_fp();
      y = rand_fp();
      send(x, y);
      recv($urandom_range(0, 3));
    end

`ifdef FDIV_SEQ_PERF_EN
    check_eq("perf_ops", perf_ops, n_ops);
    check_eq("perf_special", perf_special, n_sp);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // run-time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fdiv_seq.md
Name: fdiv_seq

Overview:
- Sequencer wrapped around the iterative SRT single-precision divider core (`fdiv`).
- Accepts operand pairs on a valid/ready stream and screens IEEE-754 special operands, answering those locally.
- Issues a one-cycle `req` to the divider, holds its operands stable for the whole iteration, and captures `rslt`/`flag` after the fixed latency.
- Applies exponent overflow/underflow fix-up and presents the result on a valid/ready output stream. One operation in flight at a time.

Parameters:
- DIV_LAT, 28, clock edges from the edge at which the divider samples `req` high to the edge at which `div_rslt`/`div_flag` are final and captured.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (sampled on rising `clk`; 0 = reset)
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- in_x  in  32  dividend, IEEE single
- in_y  in  32  divisor, IEEE single
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_rslt  out  32  quotient, IEEE single
- out_flag  out  5  {NV,DZ,OF,UF,NX}, bit4..bit0
- div_req  out  1  start pulse to divider
- div_x  out  32  divider dividend, held from issue to capture
- div_y  out  32  divider divisor, held from issue to capture
- div_rslt  in  32  divider result
- div_flag  in  5  divider flags; only bit0 (NX) used

Behaviour:
- Reset (`reset`=0 at an edge): state IDLE; in_ready=1; out_valid=0; div_req=0; out_rslt=0; out_flag=0; div_x=div_y=0; latency counter=0. Reset mid-operation abandons the op. No output is produced for it. The divider core is reset from the same net.
- States:
  - IDLE: in_ready=1.
    - On in_valid, latch x,y into div_x/div_y and classify.
    - Special -> DONE with the local result.
    - Normal -> ISSUE.
  - ISSUE: in_ready=0; div_req=1 for exactly this cycle; load counter=DIV_LAT; -> RUN.
  - RUN: in_ready=0; counter decrements each edge. On the edge where counter==1, capture div_rslt/div_flag with fix-up -> DONE.
  - DONE: out_valid=1, out_rslt/out_flag stable. On out_valid&out_ready -> IDLE. in_ready=0 in DONE (no overlap).
- Latency:
  - Special: out_valid rises 1 cycle after the input handshake edge.
  - Normal: out_valid rises DIV_LAT+1 = 29 cycles after the handshake edge.
- Classification: denormal inputs (exp==0) are flushed to signed zero before classification. Priority order:
  1. Any NaN -> 0x7FC00000. NV=1 if either is signalling (exp=255, frac!=0, frac[22]=0).
  2. inf/inf or 0/0 -> 0x7FC00000, NV.
  3. x inf -> sign(x^y) inf.
  4. y zero -> sign inf, DZ.
  5. x zero or y inf -> signed zero, no flags.
  6. Otherwise normal.
- Fix-up for normal ops:
  - e = expx-expy+127 (signed 10-bit); e_adj = e - (fracx<fracy).
  - e_adj>=255 -> sign inf, flags OF|NX.
  - e_adj<=0 -> signed zero, flags UF|NX.
  - Else out_rslt=div_rslt, NX=div_flag[0].
  - If rounding pushes div_rslt[30:23] to 255 -> flags OF|NX, result = inf.
- div_x/div_y change only in IDLE on an accept; they are stable throughout ISSUE/RUN.
- Simultaneous out_ready and in_valid in DONE: the result retires; the input is not accepted that cycle.

Optional Feature:
- FDIV_SEQ_PERF_EN defined: adds output ports perf_ops[31:0] and perf_special[31:0].
  - perf_ops increments on each input handshake; perf_special on each special-classified accept.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2), out_ready=1 -> out_rslt 0x40400000, flag 0x00, out_valid 29 cycles after accept; div_req high exactly 1 cycle.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB, flag 0x01.
- 0x3F800000 / 0x00000000 -> 0x7F800000, flag 0x08, 1-cycle latency, div_req never asserted. 0x00000000/0x80000000 -> 0x7FC00000, flag 0x10. 0x7F800001/0x3F800000 -> 0x7FC00000, flag 0x10.
- 0x7F000000 / 0x3E800000 -> 0x7F800000, flag 0x05. 0x00800000 / 0x4B000000 -> 0x00000000, flag 0x03.
- Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> out_rslt stable, in_ready=0. Release -> retire, next op accepted the following cycle.
- Drive `reset`=0 at RUN count 10 -> out_valid stays 0, IDLE with in_ready=1 next cycle. A fresh 6/2 then completes correctly.
